// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment display path: digit count, digit index
// type and the active-high hex font (bit order gfedcba).
package seg7_pkg;

    localparam int DIGITS = 4;

    typedef logic [1:0] digit_idx_t;

    // Lowercase b and d keep them distinguishable from 8 and 0.
    localparam logic [6:0] HEX_FONT [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,
        7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C,
        7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [DIGITS-1:0] digit_onehot(input digit_idx_t idx);
        return DIGITS'(1) << idx;
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-high segment pattern {g,f,e,d,c,b,a}.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_hi
);

    assign seg_hi = HEX_FONT[nibble];

endmodule

// File: rtl/seg_digit_driver.sv
// Multiplexed 4-digit display driver: double-buffered value committed at frame
// boundaries, guard cycles on digit change, leading-zero blanking, registered outputs.
module seg_digit_driver
    import seg7_pkg::*;
#(
    parameter int GUARD_CYCLES = 2,
    parameter bit ACTIVE_LOW   = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  digit_sel,
    input  logic        load,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    input  logic        blank_lz,
    output logic        pending,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
    localparam logic [GW-1:0] GUARD_RELOAD = (GUARD_CYCLES > 0) ? GW'(GUARD_CYCLES - 1) : '0;
    localparam logic [3:0] AN_OFF  = {4{ACTIVE_LOW}};
    localparam logic [6:0] SEG_OFF = {7{ACTIVE_LOW}};
    localparam logic       DP_OFF  = ACTIVE_LOW;

    logic [15:0]   stage_q, stage_d, active_q, active_d;
    logic [3:0]    stage_dp_q, stage_dp_d, active_dp_q, active_dp_d;
    logic          pending_q, pending_d;
    logic [1:0]    sel_prev_q, sel_prev_d;
    logic [GW-1:0] guard_q, guard_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;

    logic          change, commit, guarded, blank;
    logic [15:0]   eff_value;
    logic [3:0]    eff_dp, nibble, an_hi;
    logic [6:0]    font_seg, seg_hi;
    logic          dp_hi;

    seg7_hex_decode u_decode (
        .nibble (nibble),
        .seg_hi (font_seg)
    );

    // On the commit cycle the staged data is shown directly so the new frame starts clean.
    always_comb begin
        change      = digit_sel != sel_prev_q;
        commit      = (sel_prev_q == 2'd3) && (digit_sel == 2'd0) && pending_q;
        eff_value   = commit ? stage_q    : active_q;
        eff_dp      = commit ? stage_dp_q : active_dp_q;
        active_d    = eff_value;
        active_dp_d = eff_dp;
        stage_d     = load ? value : stage_q;
        stage_dp_d  = load ? dp_in : stage_dp_q;
        pending_d   = load | (pending_q & ~commit);
        sel_prev_d  = digit_sel;

        guarded = 1'b0;
        guard_d = '0;
        if (GUARD_CYCLES > 0) begin
            guarded = change || (guard_q != '0);
            if (change)
                guard_d = GUARD_RELOAD;
            else if (guard_q != '0)
                guard_d = guard_q - GW'(1);
        end
    end

    // A digit is a leading zero when it and every more significant nibble are zero.
    always_comb begin
        nibble = eff_value[{digit_sel, 2'b00} +: 4];
        blank  = blank_lz && (digit_sel != 2'd0) &&
                 ((eff_value >> {digit_sel, 2'b00}) == 16'h0000);
        an_hi  = (blank || guarded) ? 4'h0 : digit_onehot(digit_sel);
        seg_hi = blank ? 7'h00 : font_seg;
        dp_hi  = !blank && eff_dp[digit_sel];
        an_d   = ACTIVE_LOW ? ~an_hi  : an_hi;
        seg_d  = ACTIVE_LOW ? ~seg_hi : seg_hi;
        dp_d   = ACTIVE_LOW ? ~dp_hi  : dp_hi;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q     <= '0;
            stage_dp_q  <= '0;
            active_q    <= '0;
            active_dp_q <= '0;
            pending_q   <= 1'b0;
            sel_prev_q  <= '0;
            guard_q     <= '0;
            an_q        <= AN_OFF;
            seg_q       <= SEG_OFF;
            dp_q        <= DP_OFF;
        end else begin
            stage_q     <= stage_d;
            stage_dp_q  <= stage_dp_d;
            active_q    <= active_d;
            active_dp_q <= active_dp_d;
            pending_q   <= pending_d;
            sel_prev_q  <= sel_prev_d;
            guard_q     <= guard_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
        end
    end

    assign pending = pending_q;
    assign an      = an_q;
    assign seg     = seg_q;
    assign dp      = dp_q;

endmodule

// File: tb/tb_seg_digit_driver.sv
// Bench for seg_digit_driver: default instance (guard 2, active-low) and a
// guard-free active-high instance share stimulus and a behavioural display model.
module tb_seg_digit_driver;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  digit_sel = 2'd0;
    logic        load = 1'b0;
    logic [15:0] value = 16'h0;
    logic [3:0]  dp_in = 4'h0;
    logic        blank_lz = 1'b0;

    logic       pend_a, pend_b, dp_a, dp_b;
    logic [3:0] an_a, an_b;
    logic [6:0] seg_a, seg_b;

    int checks = 0;
    int errors = 0;

    seg_digit_driver #(.GUARD_CYCLES(2), .ACTIVE_LOW(1'b1)) dut (
        .clk(clk), .rst(rst), .digit_sel(digit_sel), .load(load), .value(value),
        .dp_in(dp_in), .blank_lz(blank_lz), .pending(pend_a), .an(an_a), .seg(seg_a), .dp(dp_a)
    );

    seg_digit_driver #(.GUARD_CYCLES(0), .ACTIVE_LOW(1'b0)) dut_nog (
        .clk(clk), .rst(rst), .digit_sel(digit_sel), .load(load), .value(value),
        .dp_in(dp_in), .blank_lz(blank_lz), .pending(pend_b), .an(an_b), .seg(seg_b), .dp(dp_b)
    );

    always #5 clk = ~clk;

    // Independent font (active-high gfedcba): segments lit for each hex glyph.
    logic [6:0] font [16] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
        7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
        7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
        7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
    };

    logic [15:0] m_stage, m_active;
    logic [3:0]  m_sdp, m_adp;
    bit          m_pend;
    int          m_prev, m_since;
    logic [3:0]  exp_an_a, exp_an_b;
    logic [6:0]  exp_seg_a, exp_seg_b;
    logic        exp_dp_a, exp_dp_b, exp_pend;

    task automatic model_update();
        int sel, nib;
        bit blanked;
        logic [3:0] lit, an_hi_a, an_hi_b;
        logic [6:0] seg_hi;
        logic dp_hi;
        if (rst) begin
            m_stage = 0; m_active = 0; m_sdp = 0; m_adp = 0; m_pend = 0;
            m_prev = 0; m_since = 1000;
            exp_an_a = 4'hF; exp_seg_a = 7'h7F; exp_dp_a = 1'b1;
            exp_an_b = 4'h0; exp_seg_b = 7'h00; exp_dp_b = 1'b0;
            exp_pend = 1'b0;
            return;
        end
        sel = int'(digit_sel);
        if (sel != m_prev) m_since = 0;
        else if (m_since < 1000) m_since++;
        if (m_prev == 3 && sel == 0 && m_pend) begin
            m_active = m_stage; m_adp = m_sdp; m_pend = 0;
        end
        nib = int'((m_active >> (4 * sel)) & 16'hF);
        blanked = 1'b0;
        if (blank_lz && sel > 0) begin
            blanked = 1'b1;
            for (int k = sel; k < 4; k++)
                if (((m_active >> (4 * k)) & 16'hF) != 0) blanked = 1'b0;
        end
        lit     = 4'(1 << sel);
        seg_hi  = blanked ? 7'h00 : font[nib];
        dp_hi   = blanked ? 1'b0 : m_adp[sel];
        an_hi_a = (blanked || m_since < 2) ? 4'h0 : lit;
        an_hi_b = blanked ? 4'h0 : lit;
        exp_an_a = ~an_hi_a; exp_seg_a = ~seg_hi; exp_dp_a = ~dp_hi;
        exp_an_b = an_hi_b;  exp_seg_b = seg_hi;  exp_dp_b = dp_hi;
        if (load) begin
            m_stage = value; m_sdp = dp_in; m_pend = 1;
        end
        exp_pend = m_pend;
        m_prev = sel;
    endtask

    task automatic check_output(input string tag, input logic [15:0] got, input logic [15:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("[TB] FAIL %s: got %h expected %h (t=%0t)", tag, got, want, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_update();
        check_output("an_g2",    16'(an_a),   16'(exp_an_a));
        check_output("seg_g2",   16'(seg_a),  16'(exp_seg_a));
        check_output("dp_g2",    16'(dp_a),   16'(exp_dp_a));
        check_output("pend_g2",  16'(pend_a), 16'(exp_pend));
        check_output("an_g0",    16'(an_b),   16'(exp_an_b));
        check_output("seg_g0",   16'(seg_b),  16'(exp_seg_b));
        check_output("dp_g0",    16'(dp_b),   16'(exp_dp_b));
        check_output("pend_g0",  16'(pend_b), 16'(exp_pend));
    endtask

    // Holds a digit index for n cycles; an optional load strobe rides the first cycle.
    task automatic apply_stimulus(input int sel, input int n, input bit ld,
                                  input logic [15:0] v, input logic [3:0] d);
        digit_sel = 2'(sel);
        load = ld; value = v; dp_in = d;
        step();
        load = 1'b0;
        for (int i = 1; i < n; i++) step();
    endtask

    task automatic run_frame(input int hold);
        for (int s = 0; s < 4; s++) apply_stimulus(s, hold, 1'b0, 16'h0, 4'h0);
    endtask

    initial begin
        int cur, hold;
        logic [15:0] v;
        $display("[TB] start");
        rst = 1'b1;
        step(); step();
        rst = 1'b0;

        run_frame(6); run_frame(6);

        apply_stimulus(0, 6, 1'b0, 16'h0, 4'h0);
        apply_stimulus(1, 6, 1'b0, 16'h0, 4'h0);
        apply_stimulus(2, 6, 1'b1, 16'h12AF, 4'b0010);
        apply_stimulus(3, 6, 1'b0, 16'h0, 4'h0);
        run_frame(6);

        apply_stimulus(0, 6, 1'b0, 16'h0, 4'h0);
        apply_stimulus(1, 6, 1'b1, 16'h1111, 4'b0001);
        apply_stimulus(2, 6, 1'b1, 16'h2222, 4'b0100);
        apply_stimulus(3, 6, 1'b0, 16'h0, 4'h0);
        apply_stimulus(0, 6, 1'b1, 16'h3333, 4'b1000);
        apply_stimulus(1, 6, 1'b0, 16'h0, 4'h0);
        apply_stimulus(2, 6, 1'b0, 16'h0, 4'h0);
        apply_stimulus(3, 6, 1'b0, 16'h0, 4'h0);
        run_frame(6);

        blank_lz = 1'b1;
        apply_stimulus(0, 6, 1'b1, 16'h0050, 4'b1111);
        apply_stimulus(1, 6, 1'b0, 16'h0, 4'h0);
        apply_stimulus(2, 6, 1'b0, 16'h0, 4'h0);
        apply_stimulus(3, 6, 1'b0, 16'h0, 4'h0);
        run_frame(6);
        apply_stimulus(0, 6, 1'b1, 16'h0000, 4'b0000);
        apply_stimulus(1, 6, 1'b0, 16'h0, 4'h0);
        apply_stimulus(2, 6, 1'b0, 16'h0, 4'h0);
        apply_stimulus(3, 6, 1'b0, 16'h0, 4'h0);
        run_frame(6);
        blank_lz = 1'b0;

        apply_stimulus(0, 6, 1'b0, 16'h0, 4'h0);
        apply_stimulus(1, 6, 1'b0, 16'h0, 4'h0);
        apply_stimulus(2, 1, 1'b0, 16'h0, 4'h0);
        apply_stimulus(1, 6, 1'b0, 16'h0, 4'h0);
        apply_stimulus(2, 6, 1'b0, 16'h0, 4'h0);
        apply_stimulus(3, 6, 1'b0, 16'h0, 4'h0);

        // Random walk: mostly sequential refresh with occasional jumps, loads and resets.
        cur = 0;
        for (int it = 0; it < 300; it++) begin
            if ($urandom_range(0, 7) == 0) cur = $urandom_range(0, 3);
            else cur = (cur + 1) % 4;
            hold = $urandom_range(1, 7);
            blank_lz = ($urandom_range(0, 3) != 0);
            v = 16'($urandom);
            for (int k = 0; k < 4; k++)
                if ($urandom_range(0, 1) == 1) v[4*k +: 4] = 4'h0;
            if ($urandom_range(0, 99) == 0) begin
                rst = 1'b1; step(); rst = 1'b0;
            end
            apply_stimulus(cur, hold, ($urandom_range(0, 4) == 0), v, 4'($urandom));
        end
        blank_lz = 1'b0;

        run_frame(4);
        apply_stimulus(0, 4, 1'b0, 16'h0, 4'h0);
        apply_stimulus(1, 4, 1'b1, 16'hBEEF, 4'b0101);
        rst = 1'b1;
        step();
        rst = 1'b0;
        apply_stimulus(2, 4, 1'b0, 16'h0, 4'h0);
        apply_stimulus(3, 4, 1'b0, 16'h0, 4'h0);
        run_frame(6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
